// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller. Detects load-use hazards, handles taken-branch
//   flush sequences and data-memory wait stalls, and drives the PC / IF-ID /
//   ID-EX buffer control lines. Keeps saturating stall and flush counters.
//
// Parameters
//   FLUSH_CYCLES  extra ID/EX bubble cycles after a taken branch (0..7)
//   CNT_W         width of the stall / flush performance counters
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   idRsI, idRtI   source register fields of the instruction in ID
//   idUsesRtI      ID instruction reads rt as a source
//   jumpI          ID instruction is a jump
//   exMemReadI     memRead field of the ID/EX buffer
//   exRtI          rt field of the ID/EX buffer
//   branchTakenI   branch resolved taken in EX this cycle
//   memBusyI       data memory not ready, pipeline must hold
//   pcWriteO       PC load enable
//   ifIdWriteO     IF/ID buffer enable
//   ifIdFlushO     IF/ID buffer clear to NOP
//   idExWriteO     ID/EX buffer enable
//   idExBubbleO    ID/EX buffer control fields forced to 0
//   stateO         current FSM state (RUN=0, LOADUSE=1, MEMWAIT=2, FLUSH=3)
//   stallCntO      cycles with pcWriteO=0 (saturating)
//   flushCntO      cycles with idExBubbleO or ifIdFlushO set (saturating)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       idRsI,
   input  logic [4:0]       idRtI,
   input  logic             idUsesRtI,
   input  logic             jumpI,
   input  logic             exMemReadI,
   input  logic [4:0]       exRtI,
   input  logic             branchTakenI,
   input  logic             memBusyI,
   output logic             pcWriteO,
   output logic             ifIdWriteO,
   output logic             ifIdFlushO,
   output logic             idExWriteO,
   output logic             idExBubbleO,
   output logic [1:0]       stateO,
   output logic [CNT_W-1:0] stallCntO,
   output logic [CNT_W-1:0] flushCntO
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LOADUSE = 2'd1,
      MEMWAIT = 2'd2,
      FLUSH   = 2'd3
   } stateT;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

   stateT      state;
   stateT      nextState;
   stateT      evalState;
   logic [2:0] flushRem;
   logic [2:0] nextRem;
   logic       loadUse;

   assign loadUse = exMemReadI && (exRtI != 5'd0) &&
                    ((exRtI == idRsI) || (idUsesRtI && (exRtI == idRtI)));

   // MEMWAIT is transparent once memory is ready: the cycle is handled as the
   // state it interrupted (FLUSH if bubbles remain, otherwise RUN).
   always_comb begin
      evalState = state;
      if (state == MEMWAIT) begin
         evalState = (flushRem != 3'd0) ? FLUSH : RUN;
      end
   end

   always_comb begin
      pcWriteO    = 1'b1;
      ifIdWriteO  = 1'b1;
      ifIdFlushO  = 1'b0;
      idExWriteO  = 1'b1;
      idExBubbleO = 1'b0;
      nextState   = RUN;
      nextRem     = flushRem;

      if (!rst_n) begin
         // Hold the pipeline and load NOPs into both buffers.
         pcWriteO    = 1'b0;
         ifIdWriteO  = 1'b0;
         ifIdFlushO  = 1'b1;
         idExWriteO  = 1'b1;
         idExBubbleO = 1'b1;
         nextRem     = 3'd0;
      end else if (memBusyI) begin
         pcWriteO   = 1'b0;
         ifIdWriteO = 1'b0;
         idExWriteO = 1'b0;
         nextState  = MEMWAIT;
      end else if (branchTakenI) begin
         ifIdFlushO  = 1'b1;
         idExBubbleO = 1'b1;
         nextRem     = FLUSH_LOAD;
         nextState   = (FLUSH_LOAD == 3'd0) ? RUN : FLUSH;
      end else if (evalState == FLUSH) begin
         ifIdFlushO  = 1'b1;
         idExBubbleO = 1'b1;
         nextRem     = (flushRem == 3'd0) ? 3'd0 : flushRem - 3'd1;
         nextState   = (flushRem > 3'd1) ? FLUSH : RUN;
      end else if (loadUse && (evalState != LOADUSE)) begin
         pcWriteO    = 1'b0;
         ifIdWriteO  = 1'b0;
         idExBubbleO = 1'b1;
         nextState   = LOADUSE;
      end else if (jumpI) begin
         // Jump only squashes the fetched instruction; RUN stays RUN and a
         // one-cycle LOADUSE still retires to RUN as it would otherwise.
         ifIdFlushO = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         flushRem  <= 3'd0;
         stallCntO <= '0;
         flushCntO <= '0;
      end else begin
         state    <= nextState;
         flushRem <= nextRem;
         if (!pcWriteO && (stallCntO != '1)) begin
            stallCntO <= stallCntO + CNT_W'(1);
         end
         if ((idExBubbleO || ifIdFlushO) && (flushCntO != '1)) begin
            flushCntO <= flushCntO + CNT_W'(1);
         end
      end
   end

   assign stateO = state;

endmodule
